// File: rtl/serial_subtractor.sv
// Purpose : multi-cycle WIDTH-bit subtractor, fark = sayi1 - sayi2, one CHUNK-bit slice per clock
//           with the borrow carried between slices in a register.
// Latency : N = WIDTH/CHUNK cycles from the acceptance edge to out_valid; one result per N+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
// Ports   : clk, rst (async active-high), in_valid/in_ready + sayi1/sayi2 (operands),
//           out_valid/out_ready + fark/borc (result). Optional macro SERIAL_SUB_OVERFLOW_EN
//           adds the tasma (signed overflow) output.
module serial_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sayi1,
    input  logic [WIDTH-1:0] sayi2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fark,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borc,
    output logic             tasma
`else
    output logic             borc
`endif
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  fark_q, fark_d;
    logic              borrow_q;
    logic              borc_q;
    logic [IDXW-1:0]   idx_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic              tasma_q;
`endif

    logic [CHUNK-1:0]  a_slice, b_slice;
    logic [CHUNK:0]    diff;      // {borrow out, difference slice}
    logic              last_slice;

    // Slice select and one-slice subtract. Constant-index loops keep the
    // slice muxes explicit and avoid variable part-selects.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_slice = a_q[k*CHUNK +: CHUNK];
                b_slice = b_q[k*CHUNK +: CHUNK];
            end
        end
        // Zero-extended subtraction: the extra MSB goes to 1 exactly when a borrow leaves the slice.
        diff = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};

        fark_d = fark_q;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                fark_d[k*CHUNK +: CHUNK] = diff[CHUNK-1:0];
            end
        end

        last_slice = (idx_q == IDXW'(N - 1));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)   state_d = CALC;
            CALC: if (last_slice) state_d = DONE;
            DONE: if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fark_q   <= '0;
            borrow_q <= 1'b0;
            borc_q   <= 1'b0;
            idx_q    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            tasma_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= sayi1;
                        b_q      <= sayi2;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                    end
                end
                CALC: begin
                    fark_q   <= fark_d;
                    borrow_q <= diff[CHUNK];
                    if (last_slice) begin
                        // Index parks at N-1 rather than wrapping.
                        borc_q <= diff[CHUNK];
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // diff[CHUNK-1] is the MSB of the final fark.
                        tasma_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign fark      = fark_q;
    assign borc      = borc_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign tasma     = tasma_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : directed self-checking bench for serial_subtractor (WIDTH=64, CHUNK=8).
// Latency : expects out_valid exactly 8 cycles after the acceptance edge.
// Backpressure: holds out_ready low to check that the result is held stable.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sayi1, sayi2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fark;
    logic        borc;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic        tasma;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(64), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sayi1     (sayi1),
        .sayi2     (sayi2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fark      (fark),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .borc      (borc),
        .tasma     (tasma)
`else
        .borc      (borc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Present operands for one edge (the acceptance edge), scramble them
    // afterwards, then count edges until out_valid (bounded).
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, output int lat);
        in_valid = 1'b1;
        sayi1    = a;
        sayi2    = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sayi1    = ~a;
        sayi2    = ~b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One full transaction with out_ready held high.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] fark_e, input logic borc_e, input logic tasma_e);
        int lat;
        out_ready = 1'b1;
        do_op(a, b, lat);
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " fark"}, fark, fark_e);
        check({tag, " borc"}, {63'd0, borc}, {63'd0, borc_e});
        check({tag, " in_ready low in DONE"}, {63'd0, in_ready}, 64'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, " tasma"}, {63'd0, tasma}, {63'd0, tasma_e});
`else
        if (tasma_e) ;  // overflow flag only observable with the macro defined
`endif
        @(posedge clk); #1;
        check({tag, " out_valid after handoff"}, {63'd0, out_valid}, 64'd0);
        check({tag, " in_ready after handoff"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sayi1     = '0;
        sayi2     = '0;
        #1;
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset fark", fark, 64'd0);
        check("reset borc", {63'd0, borc}, 64'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("reset tasma", {63'd0, tasma}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op("5-3",     64'd5,     64'd3, 64'd2,                  1'b0, 1'b0);
        run_op("0-1",     64'd0,     64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op("100-1",   64'h100,   64'd1, 64'hFF,                 1'b0, 1'b0);
        run_op("ovf",     64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        run_op("1-max",   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,    1'b1, 1'b0);

        // Back-pressure: result held while out_ready=0, in_valid ignored.
        out_ready = 1'b0;
        do_op(64'h10, 64'h20, lat);
        check("bp latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            sayi1    = 64'h1234 + 64'(i);
            sayi2    = 64'h1;
            @(posedge clk); #1;
            check("bp out_valid", {63'd0, out_valid}, 64'd1);
            check("bp fark", fark, 64'hFFFF_FFFF_FFFF_FFF0);
            check("bp borc", {63'd0, borc}, 64'd1);
            check("bp in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", {63'd0, out_valid}, 64'd0);
        check("bp release in_ready", {63'd0, in_ready}, 64'd1);

        // Reset during the third CALC cycle: slice 0 (0x33) is already written.
        in_valid = 1'b1;
        sayi1    = 64'h1234;
        sayi2    = 64'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid-calc fark partial", fark & 64'hFF, 64'h33);
        rst = 1'b1;
        #1;
        check("mid rst in_ready", {63'd0, in_ready}, 64'd1);
        check("mid rst out_valid", {63'd0, out_valid}, 64'd0);
        check("mid rst fark", fark, 64'd0);
        check("mid rst borc", {63'd0, borc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("7-7 after rst", 64'd7, 64'd7, 64'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
